// File: rtl/sha_block_ctrl_if.sv
// Handshake and control bundle between the SHA-256 block sequencer and its neighbours.
// master = upstream/testbench side, slave = the sequencer itself.
interface sha_block_ctrl_if #(
  parameter int MAX_BLOCKS = 8,
  parameter int ROUNDS     = 64
);
  localparam int BLK_W = $clog2(MAX_BLOCKS + 1);
  localparam int RND_W = $clog2(ROUNDS);

  logic             start;
  logic [BLK_W-1:0] num_blocks;
  logic             abort;
  logic             blk_valid;
  logic             blk_ready;
  logic             init_hash;
  logic             load_w;
  logic             round_en;
  logic [RND_W-1:0] round_idx;
  logic             update_hash;
  logic             busy;
  logic             done;
  logic             hash_valid;

  modport master (
    output start, num_blocks, abort, blk_valid,
    input  blk_ready, init_hash, load_w, round_en, round_idx,
           update_hash, busy, done, hash_valid
  );

  modport slave (
    input  start, num_blocks, abort, blk_valid,
    output blk_ready, init_hash, load_w, round_en, round_idx,
           update_hash, busy, done, hash_valid
  );
endinterface

// File: rtl/sha_block_ctrl.sv
// SHA-256 compression sequencer: initial hash load, block handshake, round stepping,
// per-block hash update and completion signalling for multi-block messages.
module sha_block_ctrl #(
  parameter int MAX_BLOCKS = 8,
  parameter int ROUNDS     = 64
) (
  input  logic              clk,
  input  logic              rst,
  sha_block_ctrl_if.slave   bus
);
  localparam int BLK_W = $clog2(MAX_BLOCKS + 1);
  localparam int RND_W = $clog2(ROUNDS);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    WAIT_BLK,
    ROUND,
    UPDATE,
    FINISH
  } state_t;

  state_t           state_q, state_d;
  logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
  logic [BLK_W-1:0] nblk_q, nblk_d;
  logic [RND_W-1:0] round_idx_q, round_idx_d;
  logic             hash_valid_q, hash_valid_d;
  logic             start_ok;

  // Zero-length and oversized messages are dropped silently.
  assign start_ok = bus.start && (bus.num_blocks != '0) &&
                    (bus.num_blocks <= BLK_W'(MAX_BLOCKS));

  always_comb begin
    state_d      = state_q;
    blk_cnt_d    = blk_cnt_q;
    nblk_d       = nblk_q;
    round_idx_d  = '0;
    hash_valid_d = hash_valid_q;
    if (bus.abort) begin
      state_d      = IDLE;
      hash_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            state_d      = INIT;
            nblk_d       = bus.num_blocks;
            hash_valid_d = 1'b0;
          end
        end
        INIT: begin
          blk_cnt_d = '0;
          state_d   = WAIT_BLK;
        end
        WAIT_BLK: begin
          if (bus.blk_valid) state_d = ROUND;
        end
        ROUND: begin
          if (round_idx_q == RND_W'(ROUNDS - 1)) state_d = UPDATE;
          else round_idx_d = round_idx_q + 1'b1;
        end
        UPDATE: begin
          blk_cnt_d = blk_cnt_q + 1'b1;
          state_d   = (blk_cnt_q == nblk_q - 1'b1) ? FINISH : WAIT_BLK;
        end
        FINISH: begin
          hash_valid_d = 1'b1;
          state_d      = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      blk_cnt_q    <= '0;
      nblk_q       <= '0;
      round_idx_q  <= '0;
      hash_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      blk_cnt_q    <= blk_cnt_d;
      nblk_q       <= nblk_d;
      round_idx_q  <= round_idx_d;
      hash_valid_q <= hash_valid_d;
    end
  end

  // Side-effecting strobes are suppressed in a cycle that carries abort.
  assign bus.blk_ready   = (state_q == WAIT_BLK);
  assign bus.load_w      = (state_q == WAIT_BLK) && bus.blk_valid && !bus.abort;
  assign bus.init_hash   = (state_q == INIT);
  assign bus.round_en    = (state_q == ROUND);
  assign bus.round_idx   = round_idx_q;
  assign bus.update_hash = (state_q == UPDATE) && !bus.abort;
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == FINISH) && !bus.abort;
  assign bus.hash_valid  = hash_valid_q;
endmodule

// File: tb/tb_sha_block_ctrl.sv
// Randomized bench for sha_block_ctrl against a message-timeline reference model.
module tb_sha_block_ctrl;
  localparam int MAXB = 8;
  localparam int R    = 64;
  localparam int BW   = $clog2(MAXB + 1);
  localparam int RW   = $clog2(R);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sha_block_ctrl_if #(.MAX_BLOCKS(MAXB), .ROUNDS(R)) bus ();
  sha_block_ctrl #(.MAX_BLOCKS(MAXB), .ROUNDS(R)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Current message description used by the model
  int s_per;
  int nblk;
  int abort_at;
  int dly [MAXB];
  bit hv_prev = 1'b0;

  logic [13:0] obs_q [$];
  logic [13:0] exp_q [$];
  int          per_q [$];
  logic [13:0] hist_obs [$];
  bit          hist_vld [$];

  // Observation vector: {blk_ready, init_hash, load_w, round_en, round_idx[5:0],
  //                      update_hash, busy, done, hash_valid}
  function automatic logic [13:0] get_obs();
    return {bus.blk_ready, bus.init_hash, bus.load_w, bus.round_en, bus.round_idx,
            bus.update_hash, bus.busy, bus.done, bus.hash_valid};
  endfunction

  // Reference: lays the message out on a timeline of periods and reports what
  // must be visible in period n, plus what blk_valid must be in that period.
  function automatic void model(input int n, output logic [13:0] e,
                                output bit v_fixed, output bit v_val);
    bit br = 0, ih = 0, lw = 0, re = 0, uh = 0, bz = 0, dn = 0, hv;
    int ri = 0;
    int t;
    hv = hv_prev;
    v_fixed = 0;
    v_val = 0;
    if (abort_at >= 0 && n > abort_at) begin
      e = '0;
      return;
    end
    if (n > s_per) begin
      hv = 0;
      t = s_per + 1;
      if (n == t) begin ih = 1; bz = 1; end
      t++;
      for (int i = 0; i < nblk; i++) begin
        if (n >= t && n < t + dly[i]) begin br = 1; bz = 1; v_fixed = 1; v_val = 0; end
        t += dly[i];
        if (n == t) begin br = 1; lw = 1; bz = 1; v_fixed = 1; v_val = 1; end
        if (n > t && n <= t + R) begin re = 1; bz = 1; ri = n - t - 1; end
        if (n == t + R + 1) begin uh = 1; bz = 1; end
        t += R + 2;
      end
      if (n == t) begin dn = 1; bz = 1; end
      if (n > t) hv = 1;
    end
    if (n == abort_at) begin lw = 0; uh = 0; dn = 0; end
    e = {br, ih, lw, re, RW'(ri), uh, bz, dn, hv};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.start     = 1'b0;
      bus.abort     = 1'b0;
      bus.blk_valid = 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  // Drives one message (optionally aborted or cut short) and records obs/expected.
  task automatic run_msg(input int nb, input int ab_rel, input int stop_rel);
    int last, busy_end;
    logic [13:0] e;
    bit vf, vv;
    obs_q.delete(); exp_q.delete(); per_q.delete();
    s_per    = cyc;
    nblk     = nb;
    abort_at = (ab_rel >= 0) ? s_per + ab_rel : -1;
    busy_end = s_per + 2 + nb * (R + 2);
    for (int i = 0; i < nb; i++) busy_end += dly[i];
    if (abort_at >= 0) busy_end = abort_at;
    last = (stop_rel >= 0) ? s_per + stop_rel : busy_end + 2;
    while (cyc <= last) begin
      model(cyc, e, vf, vv);
      bus.start      = (cyc == s_per) ? 1'b1 :
                       ((cyc > s_per && cyc <= busy_end) ? 1'($urandom_range(0, 1)) : 1'b0);
      bus.num_blocks = (cyc == s_per) ? BW'(nb) : BW'($urandom_range(0, 15));
      bus.abort      = (cyc == abort_at);
      bus.blk_valid  = vf ? vv : 1'($urandom_range(0, 1));
      #1;
      obs_q.push_back(get_obs());
      exp_q.push_back(e);
      per_q.push_back(cyc);
      hist_obs.push_back(get_obs());
      hist_vld.push_back(bus.blk_valid);
      tick();
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    hv_prev = (abort_at >= 0) ? 1'b0 : 1'b1;
    $display("msg: blocks=%0d start_period=%0d abort_rel=%0d periods=%0d", nb, s_per, ab_rel, obs_q.size());
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    n_cmp++;
    if (get_obs() !== 14'd0) begin
      n_bad++;
      $display("FAIL reset_hold: got %b want %b", get_obs(), 14'd0);
    end
    rst = 1'b0;
    idle(1);
    n_cmp++;
    if (get_obs() !== 14'd0) begin
      n_bad++;
      $display("FAIL reset_release: got %b want %b", get_obs(), 14'd0);
    end
    hv_prev = 1'b0;
    $display("reset: checked");
  endtask

  task automatic test_single_block();
    int done_rel = -1, rounds = 0;
    for (int i = 0; i < MAXB; i++) dly[i] = 0;
    run_msg(1, -1, -1);
    for (int i = 0; i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL single period %0d: got %b want %b", per_q[i], obs_q[i], exp_q[i]);
      end
      if (obs_q[i][1] && done_rel < 0) done_rel = per_q[i] - s_per;
      if (obs_q[i][10]) rounds++;
    end
    n_cmp++;
    if (done_rel !== 68) begin
      n_bad++;
      $display("FAIL single_done_latency: got %0d want %0d", done_rel, 68);
    end
    n_cmp++;
    if (rounds !== R) begin
      n_bad++;
      $display("FAIL single_round_count: got %0d want %0d", rounds, R);
    end
  endtask

  task automatic test_multi_wait();
    int done_rel = -1, loads = 0, upds = 0;
    for (int i = 0; i < MAXB; i++) dly[i] = 0;
    dly[1] = 5;
    run_msg(3, -1, -1);
    for (int i = 0; i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL multi period %0d: got %b want %b", per_q[i], obs_q[i], exp_q[i]);
      end
      if (obs_q[i][1] && done_rel < 0) done_rel = per_q[i] - s_per;
      if (obs_q[i][11]) loads++;
      if (obs_q[i][3]) upds++;
    end
    n_cmp++;
    if (done_rel !== 2 + 3 * 66 + 5) begin
      n_bad++;
      $display("FAIL multi_done_latency: got %0d want %0d", done_rel, 2 + 3 * 66 + 5);
    end
    n_cmp++;
    if (loads !== 3 || upds !== 3) begin
      n_bad++;
      $display("FAIL multi_pulse_count: got load_w=%0d update=%0d want 3/3", loads, upds);
    end
  endtask

  task automatic test_random();
    for (int m = 0; m < 6; m++) begin
      for (int i = 0; i < MAXB; i++) dly[i] = $urandom_range(0, 3);
      idle($urandom_range(0, 3));
      run_msg($urandom_range(1, MAXB), -1, -1);
      for (int i = 0; i < obs_q.size(); i++) begin
        n_cmp++;
        if (obs_q[i] !== exp_q[i]) begin
          n_bad++;
          $display("FAIL random_msg%0d period %0d: got %b want %b", m, per_q[i], obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_ignored_start();
    int bad_nb [2] = '{0, 9};
    logic [13:0] want;
    want = {13'd0, hv_prev};
    for (int k = 0; k < 2; k++) begin
      bus.start      = 1'b1;
      bus.abort      = 1'b0;
      bus.num_blocks = BW'(bad_nb[k]);
      bus.blk_valid  = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int j = 0; j < 3; j++) begin
        #1;
        n_cmp++;
        if (get_obs() !== want) begin
          n_bad++;
          $display("FAIL ignored_start nb=%0d: got %b want %b", bad_nb[k], get_obs(), want);
        end
        tick();
      end
      $display("ignored start: num_blocks=%0d", bad_nb[k]);
    end
  endtask

  task automatic test_abort();
    for (int i = 0; i < MAXB; i++) dly[i] = 0;
    // Round 30 of block 2: INIT, WAIT, one full block (R+2), WAIT, then 30 rounds in.
    run_msg(3, 2 + (R + 2) + 1 + 30, -1);
    for (int i = 0; i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL abort period %0d: got %b want %b", per_q[i], obs_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (obs_q[2 + (R + 2) + 1 + 30][9:4] !== 6'd30) begin
      n_bad++;
      $display("FAIL abort_round_idx: got %0d want %0d", obs_q[2 + (R + 2) + 1 + 30][9:4], 30);
    end
    run_msg(1, -1, -1);
    for (int i = 0; i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL after_abort period %0d: got %b want %b", per_q[i], obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_rst_mid();
    for (int i = 0; i < MAXB; i++) dly[i] = 0;
    run_msg(2, -1, 20);
    for (int i = 0; i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL pre_rst period %0d: got %b want %b", per_q[i], obs_q[i], exp_q[i]);
      end
    end
    rst = 1'b1;
    bus.blk_valid = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (get_obs() !== 14'd0) begin
      n_bad++;
      $display("FAIL rst_mid_round: got %b want %b", get_obs(), 14'd0);
    end
    hv_prev = 1'b0;
    tick();
    $display("rst mid-round: checked");
  endtask

  task automatic test_abort_start_idle();
    for (int i = 0; i < MAXB; i++) dly[i] = 0;
    run_msg(1, -1, -1);
    bus.start      = 1'b1;
    bus.abort      = 1'b1;
    bus.num_blocks = BW'(3);
    bus.blk_valid  = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    #1;
    n_cmp++;
    if (get_obs() !== 14'd0) begin
      n_bad++;
      $display("FAIL abort_with_start: got %b want %b", get_obs(), 14'd0);
    end
    hv_prev = 1'b0;
    tick();
    $display("abort+start in idle: checked");
  endtask

  task automatic test_invariants();
    int strobes;
    for (int i = 0; i < hist_obs.size(); i++) begin
      strobes = int'(hist_obs[i][12]) + int'(hist_obs[i][11]) + int'(hist_obs[i][10]) +
                int'(hist_obs[i][3]) + int'(hist_obs[i][1]);
      n_cmp++;
      if (strobes > 1) begin
        n_bad++;
        $display("FAIL onehot entry %0d: got %0d strobes want <=1", i, strobes);
      end
      n_cmp++;
      if (hist_obs[i][11] && !(hist_vld[i] && hist_obs[i][13])) begin
        n_bad++;
        $display("FAIL load_w_handshake entry %0d: got valid=%0d ready=%0d want both 1", i, hist_vld[i], hist_obs[i][13]);
      end
      if (i > 0) begin
        n_cmp++;
        if (hist_obs[i][1] && hist_obs[i-1][1]) begin
          n_bad++;
          $display("FAIL done_width entry %0d: got 2-cycle done want 1", i);
        end
      end
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.num_blocks = '0;
    bus.blk_valid  = 1'b0;
    test_reset();
    test_single_block();
    test_multi_wait();
    test_random();
    test_ignored_start();
    test_abort();
    test_rst_mid();
    test_abort_start_idle();
    test_invariants();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
